// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Sizes are fixed to the 4:1 mux this block sits in front of.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: scans the effective requests starting one
// past the last owner, so the previous owner has the lowest priority.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] er,
  input  logic [SEL_W-1:0] last,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // NOTE: every signal written here gets a default before any branch, otherwise
  // synthesis infers a latch to hold the value on the paths that skip it.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = last;
    for (int k = 1; k <= N_REQ; k++) begin
      // k = N_REQ wraps back to last itself, which is searched last.
      cand = last + SEL_W'(k);
      if (!valid && er[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin sequencer for a shared 4:1 mux: grants one requester at a time
// for at most MAX_HOLD cycles, with a dead cycle between owners.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [N_REQ-1:0] REQ,
  input  logic [N_REQ-1:0] MASK,
  output logic [SEL_W-1:0] S,
  output logic             EN,
  output logic [N_REQ-1:0] GNT,
  output logic             BUSY,
  output logic             EXPIRE
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] s_d;
  logic             en_d, busy_d, expire_d;
  logic [N_REQ-1:0] gnt_d;

  logic [N_REQ-1:0] er;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;

  assign er = REQ & ~MASK;

  // last_q is already updated when sitting in GAP, so the released owner
  // drops to the bottom of the search order for this arbitration.
  rr_pick u_pick (
    .er    (er),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    s_d      = S;
    en_d     = 1'b0;
    gnt_d    = '0;
    busy_d   = 1'b0;
    expire_d = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_d = OWN;
          s_d     = pick_idx;
          cnt_d   = CNT_W'(1);
          en_d    = 1'b1;
          gnt_d   = onehot(pick_idx);
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      OWN: begin
        if (er[S] && (cnt_q < HOLD_LIM)) begin
          cnt_d  = cnt_q + CNT_W'(1);
          en_d   = 1'b1;
          gnt_d  = GNT;
          busy_d = 1'b1;
        end else begin
          // A drop coinciding with the limit is a normal release, hence er[S].
          state_d  = GAP;
          last_d   = S;
          cnt_d    = '0;
          expire_d = er[S];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      last_q  <= SEL_W'(N_REQ - 1);
      cnt_q   <= '0;
      S       <= '0;
      EN      <= 1'b0;
      GNT     <= '0;
      BUSY    <= 1'b0;
      EXPIRE  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      S       <= s_d;
      EN      <= en_d;
      GNT     <= gnt_d;
      BUSY    <= busy_d;
      EXPIRE  <= expire_d;
    end
  end

  // Structural invariants of the grant outputs.
  a_gnt_onehot0 : assert property (@(posedge CLK) disable iff (!RSTN)
    $onehot0(GNT));

  a_gnt_matches_sel : assert property (@(posedge CLK) disable iff (!RSTN)
    EN |-> (GNT == onehot(S)));

  a_expire_in_gap : assert property (@(posedge CLK) disable iff (!RSTN)
    EXPIRE |-> (!EN && !BUSY));

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: four instances with different hold limits share
// stimulus and are compared against a queue-free behavioural model.
module tb_mux_rr_arbiter;

  localparam int HOLDS [4] = '{8, 4, 2, 1};

  logic       CLK = 1'b0;
  logic       RSTN = 1'b1;
  logic [3:0] REQ = '0;
  logic [3:0] MASK = '0;

  logic [3:0][1:0] s;
  logic [3:0]      en, busy, expire;
  logic [3:0][3:0] gnt;

  mux_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_h8 (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .MASK(MASK),
    .S(s[0]), .EN(en[0]), .GNT(gnt[0]), .BUSY(busy[0]), .EXPIRE(expire[0]));
  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_h4 (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .MASK(MASK),
    .S(s[1]), .EN(en[1]), .GNT(gnt[1]), .BUSY(busy[1]), .EXPIRE(expire[1]));
  mux_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_h2 (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .MASK(MASK),
    .S(s[2]), .EN(en[2]), .GNT(gnt[2]), .BUSY(busy[2]), .EXPIRE(expire[2]));
  mux_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) u_h1 (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .MASK(MASK),
    .S(s[3]), .EN(en[3]), .GNT(gnt[3]), .BUSY(busy[3]), .EXPIRE(expire[3]));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: an owner (or none), how long it has held, who owned last.
  bit m_own  [4];
  int m_s    [4];
  int m_cnt  [4];
  int m_last [4];
  bit m_exp  [4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] er, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (er[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_own[i] = 1'b0; m_s[i] = 0; m_cnt[i] = 0; m_last[i] = 3; m_exp[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] er);
    int w;
    for (int i = 0; i < 4; i++) begin
      m_exp[i] = 1'b0;
      if (m_own[i]) begin
        if (er[m_s[i]] && m_cnt[i] < HOLDS[i]) begin
          m_cnt[i]++;
        end else begin
          m_exp[i]  = er[m_s[i]];
          m_own[i]  = 1'b0;
          m_last[i] = m_s[i];
          m_cnt[i]  = 0;
        end
      end else begin
        w = pick(er, m_last[i]);
        if (w >= 0) begin
          m_own[i] = 1'b1; m_s[i] = w; m_cnt[i] = 1;
        end
      end
    end
  endtask

  function automatic logic [8:0] pack(input int i);
    return {s[i], en[i], gnt[i], busy[i], expire[i]};
  endfunction

  function automatic logic [8:0] vec9(input int sel, input bit e, input bit x);
    logic [1:0] s2;
    logic [3:0] g;
    s2 = 2'(sel);
    g  = e ? (4'b0001 << s2) : 4'b0000;
    return {s2, e, g, e, x};
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s/h%0d s-en-gnt-busy-expire", tag, HOLDS[i]),
            int'(pack(i)), int'(vec9(m_s[i], m_own[i], m_exp[i])));
      check($sformatf("%s/h%0d gnt_onehot0", tag, HOLDS[i]),
            int'($onehot0(gnt[i])), 1);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge CLK);
    model_step(REQ & ~MASK);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    REQ  = '0;
    MASK = '0;
    model_reset();
    #1;
    compare_all("reset_async");
    @(posedge CLK);
    #1;
    compare_all("reset_hold");
    RSTN = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] mask;
    logic [1:0] s;
    logic       en;
    logic [3:0] gnt;
    logic       busy;
    logic       expire;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // Expected outputs of the MAX_HOLD=4 instance after each edge.
    tbl[0]  = '{4'b0100, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0000, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0};
    tbl[7]  = '{4'b1111, 4'b0000, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0};
    tbl[8]  = '{4'b1111, 4'b0000, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0};
    tbl[9]  = '{4'b1111, 4'b0000, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0};
    tbl[10] = '{4'b1111, 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[11] = '{4'b1111, 4'b0000, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[12] = '{4'b1111, 4'b0001, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[13] = '{4'b1111, 4'b0001, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0};
    tbl[14] = '{4'b0011, 4'b0010, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[15] = '{4'b0011, 4'b0010, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[16] = '{4'b0011, 4'b0010, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[17] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[18] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};

    #1;
    do_reset();

    // Single requester, timeout with rotation, then masking.
    for (int r = 0; r < 19; r++) begin
      REQ  = tbl[r].req;
      MASK = tbl[r].mask;
      cycle("tbl");
      check($sformatf("tbl row %0d h4", r), int'(pack(1)),
            int'({tbl[r].s, tbl[r].en, tbl[r].gnt, tbl[r].busy, tbl[r].expire}));
    end

    // Asynchronous reset while requester 2 owns with counter 5.
    do_reset();
    REQ = 4'b0100;
    for (int t = 0; t < 5; t++) cycle("pre_reset");
    check("pre_reset h8 owner2", int'(pack(0)), int'(vec9(2, 1'b1, 1'b0)));
    #2;
    RSTN = 1'b0;
    model_reset();
    #1;
    check("async_reset h8 no edge", int'(pack(0)), 0);
    compare_all("async_reset");
    REQ = 4'b1111;
    @(posedge CLK);
    #1;
    compare_all("in_reset");
    RSTN = 1'b1;
    cycle("post_reset");
    check("post_reset first grant 0", int'(pack(0)), int'(vec9(0, 1'b1, 1'b0)));

    // Timeout rotation with MAX_HOLD=4: 4 grant cycles then an expiring gap.
    do_reset();
    REQ = 4'b1111;
    for (int t = 0; t < 25; t++) begin
      cycle("rotate");
      check($sformatf("rotate h4 t=%0d", t), int'(pack(1)),
            int'(vec9((t / 5) % 4, (t % 5) < 4, (t % 5) == 4)));
    end

    // MAX_HOLD=2: request drop on the same edge the hold limit is reached.
    do_reset();
    REQ = 4'b1001;
    cycle("drop_exp");
    check("drop_exp grant0", int'(pack(2)), int'(vec9(0, 1'b1, 1'b0)));
    cycle("drop_exp");
    REQ = 4'b1000;
    cycle("drop_exp");
    check("drop_exp release no expire", int'(pack(2)), int'(vec9(0, 1'b0, 1'b0)));
    cycle("drop_exp");
    check("drop_exp next owner 3", int'(pack(2)), int'(vec9(3, 1'b1, 1'b0)));

    // MAX_HOLD=1 alternating single-cycle grants between 0 and 3.
    do_reset();
    REQ = 4'b1001;
    for (int t = 0; t < 8; t++) begin
      cycle("hold1");
      check($sformatf("hold1 h1 t=%0d", t), int'(pack(3)),
            int'(vec9(((t / 2) % 2 == 0) ? 0 : 3, (t % 2) == 0, (t % 2) == 1)));
    end

    // Random traffic: requests change occasionally so holds can reach the limit.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0) REQ = 4'($urandom);
      if ($urandom_range(0, 7) == 0) MASK = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
